// File: rtl/fp_pkg.sv
// Shared definitions for the FP add/sub datapath: widths, align-stage states
// and the aligned operand bundle handed from the align stage to the adder.
package fp_pkg;

    localparam int unsigned SIG_W  = 27;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned CNT_W  = 5;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } align_state_t;

    typedef struct packed {
        logic             big_sign;
        logic             small_sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] big_sig;
        logic [SIG_W-1:0] small_sig;
        logic             swapped;
        logic             x_nan;
        logic             y_nan;
        logic             x_inf;
        logic             y_inf;
    } aligned_t;

    // Hidden bit restored from a nonzero exponent; G/R/S start cleared.
    function automatic logic [SIG_W-1:0] make_sig(input logic [EXP_W-1:0] exp,
                                                   input logic [FRAC_W-1:0] frac);
        return {(exp != '0), frac, 3'b000};
    endfunction

endpackage

// File: rtl/fp_sticky_shift.sv
// Combinational right shift by a small amount; every bit shifted out is
// OR-ed into bit 0 so sticky information survives repeated passes.
module fp_sticky_shift
    import fp_pkg::*;
#(
    parameter int unsigned K_W = 3
) (
    input  logic [SIG_W-1:0] sig,
    input  logic [K_W-1:0]   shift,
    output logic [SIG_W-1:0] result
);

    logic [SIG_W-1:0] shifted;
    logic             lost;
    int unsigned      shift_int;

    always_comb begin
        shift_int = 32'(shift);
        lost      = 1'b0;
        for (int unsigned i = 0; i < SIG_W; i++) begin
            if (i < shift_int) lost = lost | sig[i];
        end
        shifted = sig >> shift;
        result  = {shifted[SIG_W-1:1], shifted[0] | lost};
    end

endmodule

// File: rtl/fp_align.sv
// FP add/sub align stage: orders the operand pair, restores hidden bits and
// iteratively right-shifts the small significand STEP bits per cycle.
module fp_align
    import fp_pkg::*;
#(
    parameter int unsigned STEP = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               x_sign_i,
    input  logic               y_sign_i,
    input  logic [EXP_W-1:0]   x_exp_i,
    input  logic [EXP_W-1:0]   y_exp_i,
    input  logic [FRAC_W-1:0]  x_frac_i,
    input  logic [FRAC_W-1:0]  y_frac_i,
    input  logic               x_greater_i,
    input  logic [EXP_W-1:0]   exp_shift_i,
    input  logic               x_infinity_i,
    input  logic               y_infinity_i,
    input  logic               x_nan_i,
    input  logic               y_nan_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               big_sign_o,
    output logic               small_sign_o,
    output logic [EXP_W-1:0]   exp_o,
    output logic [SIG_W-1:0]   big_sig_o,
    output logic [SIG_W-1:0]   small_sig_o,
    output logic               swapped_o,
    output logic               x_nan_o,
    output logic               y_nan_o,
    output logic               x_inf_o,
    output logic               y_inf_o,
    output logic               special_o
);

    localparam int unsigned K_W = $clog2(STEP + 1);

    align_state_t     state, state_next;
    aligned_t         r;
    logic [CNT_W-1:0] count, count_init, count_next;
    logic [K_W-1:0]   k;
    logic [SIG_W-1:0] shifted_sig;
    logic [EXP_W-1:0] big_exp_in, small_exp_in, count_raw;
    logic             in_special;

    always_comb begin
        big_exp_in   = x_greater_i ? x_exp_i : y_exp_i;
        small_exp_in = x_greater_i ? y_exp_i : x_exp_i;
        in_special   = x_infinity_i | y_infinity_i | x_nan_i | y_nan_i;
        // A denormal small operand behaves as exponent 1, so it needs one bit less.
        if (small_exp_in == '0 && big_exp_in != '0 && exp_shift_i != '0)
            count_raw = exp_shift_i - 8'd1;
        else
            count_raw = exp_shift_i;
        if (count_raw > 8'(SIG_W))
            count_init = CNT_W'(SIG_W);
        else
            count_init = count_raw[CNT_W-1:0];
    end

    always_comb begin
        if (32'(count) > STEP) k = K_W'(STEP);
        else                   k = K_W'(count);
        count_next = count - CNT_W'(k);
    end

    fp_sticky_shift #(.K_W(K_W)) u_shift (
        .sig    (r.small_sig),
        .shift  (k),
        .result (shifted_sig)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (valid_i) state_next = (in_special || count_init == '0) ? DONE : SHIFT;
            SHIFT: if (count_next == '0) state_next = DONE;
            DONE:  if (ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            r     <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && valid_i) begin
                r.big_sign   <= x_greater_i ? x_sign_i : y_sign_i;
                r.small_sign <= x_greater_i ? y_sign_i : x_sign_i;
                r.exp        <= big_exp_in;
                r.big_sig    <= x_greater_i ? make_sig(x_exp_i, x_frac_i)
                                            : make_sig(y_exp_i, y_frac_i);
                r.small_sig  <= x_greater_i ? make_sig(y_exp_i, y_frac_i)
                                            : make_sig(x_exp_i, x_frac_i);
                r.swapped    <= ~x_greater_i;
                r.x_nan      <= x_nan_i;
                r.y_nan      <= y_nan_i;
                r.x_inf      <= x_infinity_i;
                r.y_inf      <= y_infinity_i;
                count        <= in_special ? '0 : count_init;
            end else if (state == SHIFT) begin
                r.small_sig <= shifted_sig;
                count       <= count_next;
            end
        end
    end

    assign ready_o      = (state == IDLE);
    assign valid_o      = (state == DONE);
    assign big_sign_o   = r.big_sign;
    assign small_sign_o = r.small_sign;
    assign exp_o        = r.exp;
    assign big_sig_o    = r.big_sig;
    assign small_sig_o  = r.small_sig;
    assign swapped_o    = r.swapped;
    assign x_nan_o      = r.x_nan;
    assign y_nan_o      = r.y_nan;
    assign x_inf_o      = r.x_inf;
    assign y_inf_o      = r.y_inf;
    assign special_o    = r.x_nan | r.y_nan | r.x_inf | r.y_inf;

endmodule

// File: doc/fp_align.md
Name: fp_align

Overview:
- Second stage of the FP add/sub datapath; sits directly downstream of the operand-decomposition stage and consumes its sign/exponent/fraction/shift/special-flag outputs.
- Registers one operand pair per transaction and restores hidden bits. Orders the pair into big/small and right-shifts the small significand by the exponent difference, with guard/round/sticky.
- Presents aligned significands to the adder stage over a valid/ready handshake.
- Shifting is iterative, STEP bits per cycle, to keep the shifter small.

Parameters:
- STEP, 4, maximum right-shift per SHIFT cycle; power of two, range 1..32.
- SIG_W, 27, aligned significand width: {hidden, frac[22:0], G, R, S}; fixed, not to be overridden.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- valid_i  in  1  upstream operand pair valid
- ready_o  out  1  block can accept a pair
- x_sign_i, y_sign_i  in  1 each  operand signs
- x_exp_i, y_exp_i  in  8 each  biased exponents
- x_frac_i, y_frac_i  in  23 each  fractions
- x_greater_i  in  1  x exponent strictly greater than y exponent
- exp_shift_i  in  8  |x_exp - y_exp|
- x_infinity_i, y_infinity_i, x_nan_i, y_nan_i  in  1 each  special flags
- valid_o  out  1  aligned result valid
- ready_i  in  1  downstream accepts
- big_sign_o, small_sign_o  out  1 each  signs after ordering
- exp_o  out  8  big operand exponent (result exponent before normalise)
- big_sig_o, small_sig_o  out  SIG_W each  aligned significands
- swapped_o  out  1  1 when y is the big operand (x_greater_i=0, including equal exponents)
- x_nan_o, y_nan_o, x_inf_o, y_inf_o  out  1 each  registered special flags
- special_o  out  1  OR of the four special flags

Behaviour:
- Reset: state=IDLE, all outputs 0 except ready_o=1. Reset mid-SHIFT or mid-DONE aborts the transaction and discards it.
- States: IDLE, SHIFT, DONE. ready_o=1 only in IDLE. valid_o=1 only in DONE.
- IDLE + valid_i:
  - capture the pair
  - big = x if x_greater_i, else y
  - big_sig = {exp!=0, frac, 3'b000}; small_sig built the same way
  - count = exp_shift_i − 1 when small exp==0 and big exp!=0 (denormal effective exponent 1); otherwise count = exp_shift_i
  - saturate count at SIG_W (27)
  - next state: DONE if special_o or count==0, else SHIFT
- SHIFT, each cycle:
  - k = min(STEP, count)
  - small_sig = small_sig >> k; bit0 |= OR of all bits shifted out (sticky)
  - count −= k
  - go to DONE when count reaches 0
- Shift cycles = ceil(count/STEP). Latency from accept to valid_o = 1 + ceil(count/STEP) cycles.
- Saturated count 27 yields small_sig = 0x0000001 when the small significand was nonzero, else 0.
- Special operands skip alignment. Significands are output unshifted and the flags are passed through.
- DONE: all outputs held stable while ready_i=0. valid_o&&ready_i returns to IDLE next cycle. No same-cycle re-accept (one transaction in flight).
- exp_o = big exponent unchanged. Signs are passed per ordering; no add/sub decision is made here.

Decomposition:
- Shared package fp_pkg:
  - SIG_W, EXP_W=8, FRAC_W=23, EXP_MAX=8'hFF
  - typedef align_state_t {IDLE, SHIFT, DONE}
  - packed struct aligned_t for the output bundle, reused by the adder stage
- Optional sub-module fp_sticky_shift: combinational right shift by k ≤ STEP with sticky OR. Everything else is inline.

Test Plan:
- x=0x3F800000, y=0x3F800000 -> valid_o 1 cycle after accept; big_sig=small_sig=0x4000000; swapped_o=1; exp_o=127.
- x=0x3F800000, y=0x3F000000 (shift 1) -> 1 SHIFT cycle, valid_o at cycle 2; small_sig=0x2000000; swapped_o=0.
- x=0x4B800000, y=0x3F800001 (shift 24, STEP=4) -> 6 SHIFT cycles, valid_o at cycle 7; small_sig=0x0000005 (G=1, S=1).
- x=0x3F800000, y=0x00000001 (denormal, count 126 saturated to 27) -> small_sig=0x0000001.
- x=0x7FC00000, y=0x3F800000 -> DONE next cycle; x_nan_o=1, special_o=1.
- Handshake and reset:
  - ready_i held 0 for 3 cycles in DONE -> outputs stable, ready_o=0.
  - rst_n_i pulsed low during SHIFT -> state IDLE, valid_o=0, ready_o=1.
